// File: rtl/mem_bus_responder.sv
// Memory-side bus responder: one read or write per handshake, with programmable wait states
// and a registered drive enable for read data onto the shared board bus.
module mem_bus_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Adr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_oe,
    output logic              ready,
    output logic              busy
);
    localparam int unsigned Depth = 2 ** ADDR_W;

    typedef enum logic [1:0] {StIdle, StWait, StDone, StTurn} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              oe_q, oe_d;
    logic              busy_q, busy_d;
    logic              enter_done;
    logic              mem_we;

    logic [DATA_W-1:0] mem [Depth];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    we_d    = MemWrite;
                    adr_d   = Adr;
                    wdata_d = wdata;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? StDone : StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StTurn;
            StTurn:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // The access commits on the edge that enters DONE, using the values latched for it
    // (the *_d copies cover the zero-wait case where capture and commit share one edge).
    always_comb begin
        enter_done = (state_d == StDone) && (state_q != StDone);
        mem_we     = reset && enter_done && we_d;
        rdata_d    = (enter_done && !we_d) ? mem[adr_d] : rdata_q;
        ready_d    = enter_done;
        oe_d       = enter_done && !we_d;
        busy_d     = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[adr_d] <= wdata_d;
        end
    end

    assign rdata    = rdata_q;
    assign rdata_oe = oe_q;
    assign ready    = ready_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: three instances (1, 0 and 3 wait states) checked every cycle
// against a transaction-timing model, plus directed literal expectations.
module tb_mem_bus_responder;
    localparam int NI = 3;
    localparam int WS [NI] = '{1, 0, 3};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req [NI];
    logic        we  [NI];
    logic [7:0]  adr [NI];
    logic [15:0] wd  [NI];
    logic [15:0] rd  [NI];
    logic        oe  [NI];
    logic        rdy [NI];
    logic        bsy [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_bus_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .reset(rst_n), .req(req[0]), .MemWrite(we[0]), .Adr(adr[0]),
        .wdata(wd[0]), .rdata(rd[0]), .rdata_oe(oe[0]), .ready(rdy[0]), .busy(bsy[0])
    );
    mem_bus_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(rst_n), .req(req[1]), .MemWrite(we[1]), .Adr(adr[1]),
        .wdata(wd[1]), .rdata(rd[1]), .rdata_oe(oe[1]), .ready(rdy[1]), .busy(bsy[1])
    );
    mem_bus_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset(rst_n), .req(req[2]), .MemWrite(we[2]), .Adr(adr[2]),
        .wdata(wd[2]), .rdata(rd[2]), .rdata_oe(oe[2]), .ready(rdy[2]), .busy(bsy[2])
    );

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: an access occupies edges E0..E0+W+2; k counts edges since capture.
    bit          m_act [NI];
    int          m_k   [NI];
    logic        m_we  [NI];
    logic [7:0]  m_adr [NI];
    logic [15:0] m_wd  [NI];
    logic [15:0] m_rd  [NI] = '{default: 16'h0000};
    logic [15:0] m_mem [NI][256];

    task automatic commit(input int i);
        if (m_we[i]) m_mem[i][m_adr[i]] = m_wd[i];
        else         m_rd[i] = m_mem[i][m_adr[i]];
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                m_act[i] = 1'b0;
                m_k[i]   = 0;
                m_rd[i]  = 16'h0000;
            end else if (m_act[i]) begin
                m_k[i]++;
                if (m_k[i] == WS[i] + 2) m_act[i] = 1'b0;
                else if (m_k[i] == WS[i]) commit(i);
            end else if (req[i]) begin
                m_act[i] = 1'b1;
                m_k[i]   = 0;
                m_we[i]  = we[i];
                m_adr[i] = adr[i];
                m_wd[i]  = wd[i];
                if (WS[i] == 0) commit(i);
            end
        end
    end

    int          cyc = 0;
    int          rt[$];
    logic [15:0] rdq[$];

    initial forever begin
        logic e_rdy;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NI; i++) begin
            e_rdy = m_act[i] && (m_k[i] == WS[i]);
            chk($sformatf("busy%0d", i),  {15'b0, bsy[i]}, {15'b0, m_act[i]});
            chk($sformatf("ready%0d", i), {15'b0, rdy[i]}, {15'b0, e_rdy});
            chk($sformatf("oe%0d", i),    {15'b0, oe[i]},  {15'b0, e_rdy && !m_we[i]});
            chk($sformatf("rdata%0d", i), rd[i], m_rd[i]);
        end
        if (rdy[1]) rt.push_back(cyc);
        if (oe[1])  rdq.push_back(rd[1]);
    end

    task automatic access(input int i, input bit w, input logic [7:0] a, input logic [15:0] d,
                          input bit disturb, output int lat, output int npulse, output int nbusy,
                          output int noe, output logic [15:0] rv);
        @(posedge clk); #1;
        req[i] = 1'b1; we[i] = w; adr[i] = a; wd[i] = d;
        @(posedge clk); #1;
        req[i] = 1'b0;
        if (disturb) begin
            adr[i] = a + 8'd1; wd[i] = ~d; we[i] = ~w;
        end
        lat = -1; npulse = 0; nbusy = 0; noe = 0; rv = 16'hxxxx;
        for (int c = 0; c < WS[i] + 6; c++) begin
            @(negedge clk);
            if (rdy[i]) begin
                if (lat < 0) lat = c;
                npulse++;
            end
            if (bsy[i]) nbusy++;
            if (oe[i]) begin
                noe++;
                rv = rd[i];
            end
        end
    endtask

    int          lat, np, nb, no, nrdy;
    logic [15:0] rv;

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; adr[i] = 8'h00; wd[i] = 16'h0000;
        end
        repeat (2) @(negedge clk);
        chk("reset busy", {15'b0, bsy[0]}, 16'd0);
        chk("reset ready", {15'b0, rdy[0]}, 16'd0);
        chk("reset oe", {15'b0, oe[0]}, 16'd0);
        chk("reset rdata", rd[0], 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic write and readback, one wait state.
        access(0, 1'b1, 8'h10, 16'hA5C3, 1'b0, lat, np, nb, no, rv);
        chk("w10 latency", 16'(lat), 16'd1);
        chk("w10 pulses", 16'(np), 16'd1);
        chk("w10 busy cycles", 16'(nb), 16'd3);
        chk("w10 oe cycles", 16'(no), 16'd0);
        access(0, 1'b0, 8'h10, 16'h0000, 1'b0, lat, np, nb, no, rv);
        chk("r10 latency", 16'(lat), 16'd1);
        chk("r10 oe cycles", 16'(no), 16'd1);
        chk("r10 data", rv, 16'hA5C3);

        // Address extremes.
        access(0, 1'b1, 8'h00, 16'h0001, 1'b0, lat, np, nb, no, rv);
        access(0, 1'b1, 8'hFF, 16'hFFFF, 1'b0, lat, np, nb, no, rv);
        access(0, 1'b0, 8'h00, 16'h0000, 1'b0, lat, np, nb, no, rv);
        chk("r00 data", rv, 16'h0001);
        access(0, 1'b0, 8'hFF, 16'h0000, 1'b0, lat, np, nb, no, rv);
        chk("rFF data", rv, 16'hFFFF);

        // Inputs changed after capture must not affect the write.
        access(0, 1'b1, 8'h41, 16'h5555, 1'b0, lat, np, nb, no, rv);
        access(0, 1'b1, 8'h40, 16'hBEEF, 1'b1, lat, np, nb, no, rv);
        access(0, 1'b0, 8'h40, 16'h0000, 1'b0, lat, np, nb, no, rv);
        chk("r40 data", rv, 16'hBEEF);
        access(0, 1'b0, 8'h41, 16'h0000, 1'b0, lat, np, nb, no, rv);
        chk("r41 data", rv, 16'h5555);

        // Zero wait states, req held high across W,R,W,R.
        rt.delete();
        rdq.delete();
        @(posedge clk); #1;
        req[1] = 1'b1; we[1] = 1'b1; adr[1] = 8'h30; wd[1] = 16'h1111;
        @(posedge clk); #1;
        we[1] = 1'b0; adr[1] = 8'h30;
        repeat (3) @(posedge clk);
        #1;
        we[1] = 1'b1; adr[1] = 8'h31; wd[1] = 16'h2222;
        repeat (3) @(posedge clk);
        #1;
        we[1] = 1'b0; adr[1] = 8'h31;
        repeat (3) @(posedge clk);
        #1;
        req[1] = 1'b0;
        repeat (5) @(negedge clk);
        chk("b2b pulses", 16'(rt.size()), 16'd4);
        if (rt.size() == 4) begin
            for (int j = 1; j < 4; j++) chk($sformatf("b2b spacing%0d", j), 16'(rt[j] - rt[j-1]), 16'd3);
        end
        chk("b2b reads", 16'(rdq.size()), 16'd2);
        if (rdq.size() == 2) begin
            chk("b2b read0", rdq[0], 16'h1111);
            chk("b2b read1", rdq[1], 16'h2222);
        end

        // Three wait states: reset during WAIT aborts the write.
        access(2, 1'b1, 8'h20, 16'h0F0F, 1'b0, lat, np, nb, no, rv);
        chk("ws3 w latency", 16'(lat), 16'd3);
        chk("ws3 w busy cycles", 16'(nb), 16'd5);
        access(2, 1'b0, 8'h20, 16'h0000, 1'b0, lat, np, nb, no, rv);
        chk("ws3 r20 data", rv, 16'h0F0F);
        @(posedge clk); #1;
        req[2] = 1'b1; we[2] = 1'b1; adr[2] = 8'h20; wd[2] = 16'h1234;
        @(posedge clk); #1;
        req[2] = 1'b0;
        @(posedge clk); #3;
        chk("ws3 busy before reset", {15'b0, bsy[2]}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("async busy", {15'b0, bsy[2]}, 16'd0);
        chk("async ready", {15'b0, rdy[2]}, 16'd0);
        chk("async oe", {15'b0, oe[2]}, 16'd0);
        chk("async rdata", rd[2], 16'h0000);
        nrdy = 0;
        repeat (3) begin
            @(negedge clk);
            if (rdy[2]) nrdy++;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        access(2, 1'b0, 8'h20, 16'h0000, 1'b0, lat, np, nb, no, rv);
        chk("aborted pulses", 16'(nrdy), 16'd0);
        chk("ws3 r20 after abort", rv, 16'h0F0F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
